// File: rtl/wsc_wir_ctrl.sv
// wsc_wir_ctrl: IEEE 1500 wrapper instruction register and WSC decoder.
// Owns the WIR shift/update stages and the WBY bypass bit. Decodes the
// active instruction into boundary-cell controls and muxes the wrapper
// serial output.
//
// Ports:
//   clk        wrapper clock (WRCK), rising edge
//   arst_n     synchronous active-low reset
//   wsi        wrapper serial in
//   selectwir  1 = WIR path, 0 = data register path
//   capturewr  WSC capture
//   shiftwr    WSC shift
//   updatewr   WSC update
//   wbr_so     serial out of the last boundary cell
//   wbr_si     serial in to the first boundary cell (= wsi)
//   wso        wrapper serial out
//   shift      boundary-cell shift
//   capture    boundary-cell capture
//   update     boundary-cell update
//   transfer   boundary-cell transfer (tied 0)
//   mode       boundary-cell mode
//   safe       boundary-cell safe
//   io_face    1 = outward face (EXTEST), 0 = inward face
//   instr      active instruction
//   instr_upd  one-cycle pulse after each WIR update
module wsc_wir_ctrl #(
  parameter int unsigned      WIR_W     = 3,
  parameter logic [WIR_W-1:0] OP_BYPASS = WIR_W'(0),
  parameter logic [WIR_W-1:0] OP_EXTEST = WIR_W'(1),
  parameter logic [WIR_W-1:0] OP_INTEST = WIR_W'(2),
  parameter logic [WIR_W-1:0] OP_SAFE   = WIR_W'(3)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             wsi,
  input  logic             selectwir,
  input  logic             capturewr,
  input  logic             shiftwr,
  input  logic             updatewr,
  input  logic             wbr_so,
  output logic             wbr_si,
  output logic             wso,
  output logic             shift,
  output logic             capture,
  output logic             update,
  output logic             transfer,
  output logic             mode,
  output logic             safe,
  output logic             io_face,
  output logic [WIR_W-1:0] instr,
  output logic             instr_upd
);

  logic [WIR_W-1:0] r_wir_sr;
  logic [WIR_W-1:0] r_instr;
  logic             r_wby;
  logic             r_instr_upd;

  logic w_is_extest;
  logic w_is_intest;
  logic w_is_safe;
  logic w_wr_instr;
  logic w_wr_act;

  // Undefined opcodes fall out of all three compares and act as BYPASS.
  always_comb begin
    w_is_extest = (r_instr == OP_EXTEST);
    w_is_intest = (r_instr == OP_INTEST);
    w_is_safe   = (r_instr == OP_SAFE);
    w_wr_instr  = w_is_extest | w_is_intest;
    w_wr_act    = ~selectwir & w_wr_instr;
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_wir_sr    <= '0;
      r_instr     <= OP_BYPASS;
      r_wby       <= 1'b0;
      r_instr_upd <= 1'b0;
    end else begin
      r_instr_upd <= 1'b0;
      if (selectwir) begin
        if (capturewr) begin
          r_wir_sr <= WIR_W'(1);
        end else if (shiftwr) begin
          r_wir_sr <= {wsi, r_wir_sr[WIR_W-1:1]};
        end
        // Update samples the pre-edge shift stage, so a concurrent shift
        // only affects the next instruction.
        if (updatewr) begin
          r_instr     <= r_wir_sr;
          r_instr_upd <= 1'b1;
        end
      end else if (!w_wr_instr) begin
        // WBY is the selected data register for BYPASS, SAFE and undefined.
        if (capturewr) begin
          r_wby <= 1'b0;
        end else if (shiftwr) begin
          r_wby <= wsi;
        end
      end
    end
  end

  always_comb begin
    wbr_si    = wsi;
    shift     = w_wr_act & shiftwr;
    capture   = w_wr_act & capturewr & ~shiftwr;
    update    = w_wr_act & updatewr;
    transfer  = 1'b0;
    mode      = w_wr_instr | w_is_safe;
    safe      = w_is_safe;
    io_face   = w_is_extest;
    instr     = r_instr;
    instr_upd = r_instr_upd;
    if (selectwir) begin
      wso = r_wir_sr[0];
    end else if (w_wr_act) begin
      wso = wbr_so;
    end else begin
      wso = r_wby;
    end
  end

endmodule
